// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency word memory between instruction fetch and the load/store stage.
// Each access runs ISSUE -> WAIT -> RESP; MEM wins arbitration unless IF has been starved too long.
module mem_port_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [31:0]       i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic                r_own_d;
  logic [CNT_W-1:0]    r_cnt;
  logic [STV_W-1:0]    r_starve;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_if_rvalid;
  logic                r_d_rvalid;
  logic [31:0]         r_if_rdata;
  logic [31:0]         r_d_rdata;

  logic w_arb;
  logic w_starved;
  logic w_pick_if;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_unused;

  // Grants are combinational and only offered in IDLE/RESP; held off while reset is asserted.
  assign w_arb     = i_rst_n & ((r_state == S_IDLE) | (r_state == S_RESP));
  assign w_starved = (r_starve == STV_W'(STARVE_LIMIT));
  assign w_pick_if = i_if_req & (~i_d_req | w_starved);
  assign w_if_gnt  = w_arb & w_pick_if;
  assign w_d_gnt   = w_arb & i_d_req & ~w_pick_if;

  assign w_unused  = ^{i_if_addr[1:0], i_if_addr[31:ADDR_W+2], i_d_addr[1:0], i_d_addr[31:ADDR_W+2]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_own_d     <= 1'b0;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_arb) begin
        if (w_if_gnt || !i_if_req)
          r_starve <= '0;
        else if (w_d_gnt && !w_starved)
          r_starve <= r_starve + 1'b1;
      end
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_if_gnt || w_d_gnt) begin
            r_state    <= S_ISSUE;
            r_own_d    <= w_d_gnt;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_d_gnt & i_d_we;
            r_mem_addr <= w_d_gnt ? i_d_addr[ADDR_W+1:2] : i_if_addr[ADDR_W+1:2];
            if (w_d_gnt)
              r_mem_wdata <= i_d_wdata;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= CNT_W'(MEM_LAT - 1);
        end
        S_WAIT: begin
          // Memory word is valid exactly when the countdown reaches zero.
          if (r_cnt == '0) begin
            r_state <= S_RESP;
            if (r_own_d) begin
              r_d_rvalid <= 1'b1;
              if (!r_mem_we)
                r_d_rdata <= i_mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= i_mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_d_gnt     = w_d_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_stall_if  = i_if_req & ~r_if_rvalid;
  assign o_stall_mem = i_d_req & ~r_d_rvalid;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences (priority, starvation,
// 3-cycle latency, reset mid-access) and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int LIM = 3;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic if_req, d_req, d_we, if_gnt, if_rvalid, d_gnt, d_rvalid, stall_if, stall_mem, mem_en, mem_we;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic if_req3, d_req3, d_we3, if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, stall_if3, stall_mem3, mem_en3, mem_we3;
  logic [31:0] if_addr3, d_addr3, d_wdata3, if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0] mem_addr3;

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .STARVE_LIMIT(LIM)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_stall_if(stall_if), .o_stall_mem(stall_mem),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata));

  mem_port_arbiter #(.MEM_LAT(3), .ADDR_W(AW), .STARVE_LIMIT(LIM)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req3), .i_if_addr(if_addr3), .o_if_gnt(if_gnt3), .o_if_rvalid(if_rvalid3), .o_if_rdata(if_rdata3),
    .i_d_req(d_req3), .i_d_we(d_we3), .i_d_addr(d_addr3), .i_d_wdata(d_wdata3),
    .o_d_gnt(d_gnt3), .o_d_rvalid(d_rvalid3), .o_d_rdata(d_rdata3),
    .o_stall_if(stall_if3), .o_stall_mem(stall_mem3),
    .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3), .i_mem_rdata(mem_rdata3));

  // Memories: data valid exactly LAT cycles after mem_en, garbage otherwise.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] pipe1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    pipe1 <= mem_en ? mem1[mem_addr[5:0]] : (32'hBAD0_0000 ^ cyc);
    if (mem_en && mem_we) mem1[mem_addr[5:0]] <= mem_wdata;
    p3[0] <= mem_en3 ? mem3[mem_addr3[5:0]] : (32'hBAD3_0000 ^ cyc);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (mem_en3 && mem_we3) mem3[mem_addr3[5:0]] <= mem_wdata3;
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata3 = p3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v);
    tick();
    if (v.is_d) begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
    else begin if_req = 1; if_addr = v.addr; end
    @(negedge clk);
    chk("v_gnt_req", v.is_d ? d_gnt : if_gnt, 1);
    chk("v_gnt_oth", v.is_d ? if_gnt : d_gnt, 0);
    chk("v_stall", v.is_d ? stall_mem : stall_if, 1);
    chk("v_en_T", mem_en, 0);
    tick();
    @(negedge clk);
    chk("v_en", mem_en, 1);
    chk("v_addr", mem_addr, v.maddr);
    chk("v_we", mem_we, v.is_d & v.we);
    if (v.is_d && v.we) chk("v_wdata", mem_wdata, v.wdata);
    chk("v_gnt_issue", v.is_d ? d_gnt : if_gnt, 0);
    tick();
    @(negedge clk);
    chk("v_en_wait", mem_en, 0);
    chk("v_rv_wait", v.is_d ? d_rvalid : if_rvalid, 0);
    chk("v_gnt_wait", v.is_d ? d_gnt : if_gnt, 0);
    chk("v_stall_wait", v.is_d ? stall_mem : stall_if, 1);
    tick();
    d_req = 0; if_req = 0;
    @(negedge clk);
    chk("v_rvalid", v.is_d ? d_rvalid : if_rvalid, 1);
    chk("v_rv_oth", v.is_d ? if_rvalid : d_rvalid, 0);
    chk("v_rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    tick();
    @(negedge clk);
    chk("v_rv_pulse", v.is_d ? d_rvalid : if_rvalid, 0);
  endtask

  task automatic lat3_load(input logic [31:0] addr, input logic [31:0] exp);
    tick();
    d_req3 = 1; d_we3 = 0; d_addr3 = addr;
    @(negedge clk);
    chk("l3_gnt", d_gnt3, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) d_req3 = 0;
      @(negedge clk);
      chk("l3_en", mem_en3, (c == 1) ? 1 : 0);
      chk("l3_rvalid", d_rvalid3, (c == 5) ? 1 : 0);
      if (c == 1) chk("l3_addr", mem_addr3, {16'h0, addr[17:2]});
      if (c < 5) chk("l3_gnt_busy", d_gnt3, 0);
    end
    chk("l3_rdata", d_rdata3, exp);
    tick();
    @(negedge clk);
    chk("l3_rv_pulse", d_rvalid3, 0);
  endtask

  function automatic logic [31:0] raddr(input int w);
    return ($urandom & 32'hFFFC_0000) | (32'(w) << 2) | ($urandom & 32'h3);
  endfunction

  vec_t vecs [8];

  // Random-run reference model state
  logic [31:0] ref_mem [64];
  int  free_at, en_at, resp_at, starve;
  bit  m_own_d, m_we, if_pend, if_busy, d_pend, d_busy;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata, e_if_rdata, e_d_rdata;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'h1000_0000 + 32'(i);
      mem3[i] = 32'h1000_0000 + 32'(i);
    end
    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         16'd4, 32'h1000_0004};
    vecs[1] = '{1, 0, 32'h0000_0014, 32'h0,         16'd5, 32'h1000_0005};
    vecs[2] = '{1, 1, 32'h0000_0020, 32'hDEADBEEF,  16'd8, 32'h1000_0005};
    vecs[3] = '{1, 0, 32'h0000_0023, 32'h0,         16'd8, 32'hDEADBEEF};
    vecs[4] = '{1, 1, 32'hFFFC_0024, 32'h12345678,  16'd9, 32'hDEADBEEF};
    vecs[5] = '{0, 0, 32'h0000_0026, 32'h0,         16'd9, 32'h12345678};
    vecs[6] = '{0, 0, 32'h0000_0020, 32'h0,         16'd8, 32'hDEADBEEF};
    vecs[7] = '{1, 0, 32'h0000_0000, 32'h0,         16'd0, 32'h1000_0000};

    rst_n = 0;
    if_req = 1; if_addr = 32'h10; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    if_req = 0;
    tick();
    rst_n = 1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Simultaneous requests: MEM store first, IF granted in MEM's RESP cycle.
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("both_d_gnt", d_gnt, 1);
    chk("both_if_gnt0", if_gnt, 0);
    tick();
    @(negedge clk);
    chk("both_en", mem_en, 1);
    chk("both_we", mem_we, 1);
    chk("both_addr", mem_addr, 8);
    chk("both_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    tick();
    d_req = 0;
    @(negedge clk);
    chk("both_d_rvalid", d_rvalid, 1);
    chk("both_if_gnt", if_gnt, 1);
    chk("both_stall_if", stall_if, 1);
    tick();
    @(negedge clk);
    chk("both_if_en", mem_en, 1);
    chk("both_if_we", mem_we, 0);
    chk("both_if_addr", mem_addr, 4);
    tick();
    @(negedge clk);
    chk("both_if_rv_early", if_rvalid, 0);
    tick();
    if_req = 0;
    @(negedge clk);
    chk("both_if_rvalid", if_rvalid, 1);
    chk("both_if_rdata", if_rdata, 32'h1000_0004);

    // Starvation guard: with both requests held, three MEM grants then one IF grant, repeating.
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h30; if_req = 1; if_addr = 32'h10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stv_d_gnt", d_gnt, (k % 4 == 3) ? 0 : 1);
      chk("stv_if_gnt", if_gnt, (k % 4 == 3) ? 1 : 0);
      tick(); tick(); tick();
    end
    d_req = 0; if_req = 0;
    @(negedge clk);
    chk("stv_drain_gnt", {if_gnt, d_gnt}, 0);
    repeat (2) tick();

    lat3_load(32'h14, 32'h1000_0005);

    // Reset during WAIT on the 3-cycle memory.
    tick();
    d_req3 = 1; d_we3 = 0; d_addr3 = 32'h18;
    @(negedge clk);
    chk("rw_gnt", d_gnt3, 1);
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("rw_gnt_rst", d_gnt3, 0);
    chk("rw_en_rst", mem_en3, 0);
    chk("rw_rv_rst", d_rvalid3, 0);
    chk("rw_addr_rst", mem_addr3, 0);
    tick();
    d_req3 = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rw_no_rvalid", d_rvalid3, 0);
      chk("rw_no_en", mem_en3, 0);
      tick();
    end
    chk("rw_rdata_clr", d_rdata3, 0);
    lat3_load(32'h1C, 32'h1000_0007);
    repeat (2) tick();

    // Randomized run on the single-cycle memory against the transaction model.
    for (int i = 0; i < 64; i++) ref_mem[i] = mem1[i];
    free_at = 0; en_at = -1; resp_at = -1; starve = 0;
    if_pend = 0; if_busy = 0; d_pend = 0; d_busy = 0;
    e_if_rdata = 0; e_d_rdata = 0;
    m_own_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    for (int cc = 0; cc < 600; cc++) begin
      bit if_done, d_done, e_en, e_we, arb, pick_if, e_ifg, e_dg;
      logic [15:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] ga;
      tick();
      if_done = (cc == resp_at) && !m_own_d;
      d_done  = (cc == resp_at) && m_own_d;
      if (!if_pend && !(if_busy && !if_done)) begin
        if_busy = 0;
        if ($urandom_range(0, 99) < 55) begin if_pend = 1; if_req = 1; if_addr = raddr($urandom_range(0, 63)); end
        else if_req = 0;
      end
      if (!d_pend && !(d_busy && !d_done)) begin
        d_busy = 0;
        if ($urandom_range(0, 99) < 60) begin
          d_pend = 1; d_req = 1; d_we = ($urandom_range(0, 2) == 0);
          d_addr = raddr($urandom_range(0, 63)); d_wdata = $urandom;
        end else d_req = 0;
      end
      if (if_done) e_if_rdata = m_rdata;
      if (d_done && !m_we) e_d_rdata = m_rdata;
      e_en = (cc == en_at); e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
      arb = (cc >= free_at);
      pick_if = if_req && (!d_req || starve == LIM);
      e_ifg = arb && pick_if;
      e_dg  = arb && d_req && !pick_if;
      if (arb) begin
        if (e_ifg || !if_req) starve = 0;
        else if (e_dg && starve < LIM) starve++;
      end
      if (e_ifg || e_dg) begin
        ga = e_dg ? d_addr : if_addr;
        m_own_d = e_dg; m_we = e_dg && d_we; m_addr = ga[17:2];
        if (e_dg) m_wdata = d_wdata;
        m_rdata = ref_mem[m_addr[5:0]];
        if (m_we) ref_mem[m_addr[5:0]] = d_wdata;
        en_at = cc + 1; resp_at = cc + LAT + 2; free_at = cc + LAT + 2;
        if (e_ifg) begin if_pend = 0; if_busy = 1; end
        else begin d_pend = 0; d_busy = 1; end
      end
      @(negedge clk);
      chk("r_if_gnt", if_gnt, e_ifg);
      chk("r_d_gnt", d_gnt, e_dg);
      chk("r_mem_en", mem_en, e_en);
      if (e_en) begin
        chk("r_mem_we", mem_we, e_we);
        chk("r_mem_addr", mem_addr, e_addr);
        if (e_we) chk("r_mem_wdata", mem_wdata, e_wdata);
      end
      chk("r_if_rvalid", if_rvalid, if_done);
      chk("r_d_rvalid", d_rvalid, d_done);
      chk("r_if_rdata", if_rdata, e_if_rdata);
      chk("r_d_rdata", d_rdata, e_d_rdata);
      chk("r_stall_if", stall_if, if_req && !if_done);
      chk("r_stall_mem", stall_mem, d_req && !d_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
